// File: rtl/hb_mem_fetch.sv
// hb_mem_fetch: read-burst engine between the HBM read port and the conv datapath.
// Walks base..base+N-1, captures words into a small FIFO, streams them out valid/ready.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start                   one-cycle request, sampled only in IDLE
//   base_addr, num_words    burst descriptor, latched with start
//   busy, done              status; done pulses once per finished burst
//   mem_r_addr, mem_r_data  registered read address, combinational read data
//   out_valid/_data/_last   FIFO head and last-beat marker
//   out_ready               consumer accept
module hb_mem_fetch #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 256,
    parameter int CNT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_words,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  rem_q, rem_d;
    logic [PW-1:0]         wr_q, wr_d;
    logic [PW-1:0]         rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic                  last_mem [FIFO_DEPTH];

    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;
    logic rem_is_one;

    // Full is judged on the count at the start of the cycle, so a
    // same-cycle pop never opens a slot for this cycle's push.
    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign rem_is_one = (rem_q == CNT_WIDTH'(1));

    assign push = (state_q == S_FETCH) && !fifo_full;
    assign pop  = !fifo_empty && out_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = num_words;
                    state_d = (num_words == '0) ? S_DRAIN : S_FETCH;
                end
            end
            S_FETCH: begin
                if (push) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - CNT_WIDTH'(1);
                    if (rem_is_one) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            wr_d = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_q] <= mem_r_data;
            last_mem[wr_q] <= rem_is_one;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DRAIN) && fifo_empty;
    assign mem_r_addr = addr_q;
    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_empty ? '0 : data_mem[rd_q];
    assign out_last   = !fifo_empty && last_mem[rd_q];

endmodule

// File: doc/hb_mem_fetch.md
# hb_mem_fetch

Read-burst engine sitting directly upstream of the high-bandwidth memory's read port, between it and the convolution datapath. On a start command it walks a contiguous range of memory words, drives the memory's combinational read address, captures each returned word into a small FIFO, and streams the words out on a valid/ready interface with a last-beat marker. It is the only reader of the memory in the convolution layer.

## Interface
- ADDR_WIDTH, 20, memory word-address width (matches memory).
- DATA_WIDTH, 256, memory/stream word width.
- CNT_WIDTH, 16, width of the burst length field.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle request; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first word address; latched with start.
- num_words  input  CNT_WIDTH  burst length in words; latched with start; 0 legal.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a burst completes.
- mem_r_addr  output  ADDR_WIDTH  registered address to the memory read port.
- mem_r_data  input  DATA_WIDTH  combinational read data for mem_r_addr.
- out_valid  output  1  FIFO head is valid.
- out_data  output  DATA_WIDTH  FIFO head word.
- out_last  output  1  FIFO head is the final word of the burst.
- out_ready  input  1  consumer accepts head when out_valid & out_ready.

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: start=1 latches base_addr into mem_r_addr and num_words into remaining counter; if num_words==0 go to DRAIN (no fetch), else FETCH. start while not IDLE is ignored, no queuing.
- FETCH: each cycle with FIFO not full (count < FIFO_DEPTH), push {mem_r_data, remaining==1} at the clock edge, mem_r_addr += 1, remaining -= 1. When FIFO full, hold mem_r_addr and remaining (no push). Push on the edge where remaining==1 moves to DRAIN.
- A pop in the same cycle does not free a slot for that cycle's push decision: full means count==FIFO_DEPTH at the start of the cycle.
- DRAIN: wait until FIFO empty (count==0); then assert done for one cycle and return to IDLE in the same edge (done high in the cycle after the last pop, busy low from that same cycle onward... done and busy=0 coincide? No: done is asserted in the DRAIN cycle where count==0, busy still high; next cycle IDLE).
- Address arithmetic modulo 2^ADDR_WIDTH: 0xFFFFF + 1 wraps to 0x00000, no error.
- Simultaneous push and pop allowed; count unchanged.
- out_data/out_last stable while out_valid=1 and out_ready=0.
- out_last asserted exactly once per nonzero burst, on the final word; never for num_words==0.

## Timing
- Reset values: busy=0, done=0, mem_r_addr=0, out_valid=0, out_data=0, out_last=0; FIFO empty, state IDLE, remaining=0.
- Reset mid-burst: all state cleared immediately; FIFO contents discarded; no done pulse.
- start sampled at edge E0: FETCH from E0; mem_r_addr=base in the following cycle; first push at E1; out_valid=1 after E1 (start-to-first-valid = 2 edges).
- Throughput: with out_ready held 1, one word per cycle sustained, no bubbles.
- Burst of N words with out_ready held 1: last pop at edge E0+N+1; done high in the cycle after it; IDLE one cycle later; next start accepted then.
- num_words==0: E0 -> DRAIN; done high cycle after E0; IDLE next.

## Test plan
- Burst: memory word k = k; base=0x10, num_words=8, out_ready=1 -> out_data 0x10..0x17 on consecutive cycles, out_last only on 0x17, first valid 2 edges after start, one done pulse.
- Backpressure: num_words=12, out_ready=0 for 10 cycles then 1 -> FIFO fills to 4, mem_r_addr holds at base+4, data stable while stalled, all 12 words in order, no loss/duplication.
- Wrap: base=0xFFFFE, num_words=4 -> addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001 delivered in order.
- Zero length and ignored start: num_words=0 -> done pulse, no out_valid; start pulsed during a busy 8-word burst -> ignored, exactly 8 words and one done.
- Reset mid-burst: rst_n low after 3 words of a 16-word burst -> outputs at reset values asynchronously, no done; new burst afterwards runs correctly from its own base.
- Random out_ready (50%) over 100-word burst -> output sequence equals memory contents base..base+99, out_last on word 99 only.
